// File: rtl/spi_master_sched_pkg.sv
// spi_master_sched_pkg: FSM state type, default divider and select-width helper for spi_master_sched
package spi_sched_pkg;
   typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_HIGH, ST_LOW, ST_TAIL, ST_GAP} spim_st_t;
   localparam int CLKDIV_DEF = 4;
   function automatic int sw_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/spi_master_sched_if.sv
// spi_master_sched_if: client request/grant handshake and SPI bus pins of spi_master_sched
interface spi_master_sched_if
   import spi_sched_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int NSLV = 4
);
   localparam int SW = sw_width(NSLV);
   logic [NREQ-1:0]    req;
   logic [NREQ*8-1:0]  req_data;
   logic [NREQ*SW-1:0] req_slv;
   logic [NREQ-1:0]    gnt;
   logic [NREQ-1:0]    done;
   logic [7:0]         rx_data;
   logic               busy;
   logic               sck;
   logic               mosi;
   logic               miso;
   logic [NSLV-1:0]    ss;
   modport master (input req, req_data, req_slv, miso, output gnt, done, rx_data, busy, sck, mosi, ss);
   modport slave (output req, req_data, req_slv, miso, input gnt, done, rx_data, busy, sck, mosi, ss);
endinterface

// File: rtl/spi_master_sched_arbiter.sv
// spim_arbiter: picks one requester; SPIM_ROUND_ROBIN_EN searches from a rotating pointer, otherwise lowest index wins
module spim_arbiter #(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0]         req,
`ifdef SPIM_ROUND_ROBIN_EN
   input  logic [$clog2(NREQ)-1:0] ptr,
   output logic [$clog2(NREQ)-1:0] nxt_ptr,
`endif
   output logic [NREQ-1:0]         win,
   output logic                    valid
);
   assign valid = |req;
`ifdef SPIM_ROUND_ROBIN_EN
   localparam int PW = $clog2(NREQ);
   logic [NREQ-1:0] rot;
   logic [PW-1:0]   k;
   // rotate requests so the pointer sits at bit 0, take the lowest set bit, map it back
   always_comb begin
      rot = NREQ'({req, req} >> ptr);
      k = ptr;
      for (int i = NREQ - 1; i >= 0; i--) k = rot[i] ? PW'((int'(ptr) + i) % NREQ) : k;
      win = valid ? NREQ'(1) << k : '0;
      nxt_ptr = PW'((int'(k) + 1) % NREQ);
   end
`else
   assign win = req & (~req + NREQ'(1));
`endif
endmodule

// File: rtl/spi_master_sched.sv
// spi_master_sched: arbitrated multi-client SPI byte master; define SPIM_ROUND_ROBIN_EN for round-robin arbitration
module spi_master_sched
   import spi_sched_pkg::*;
#(
   parameter int NREQ   = 4,
   parameter int NSLV   = 4,
   parameter int CLKDIV = CLKDIV_DEF,
   parameter int GAP    = 4
) (
   input logic                Clk_i,
   input logic                Rst_ni,
   spi_master_sched_if.master bus
);
   localparam int SW = sw_width(NSLV);
   localparam int DW = $clog2((CLKDIV > GAP) ? CLKDIV : GAP);
   spim_st_t        st, nxt;
   logic [DW-1:0]   divc;
   logic [2:0]      bitc;
   logic [7:0]      tx, rx, sel_data;
   logic [SW-1:0]   slv, sel_slv;
   logic [NREQ-1:0] own, win;
   logic            valid, last, take, on;
`ifdef SPIM_ROUND_ROBIN_EN
   logic [$clog2(NREQ)-1:0] ptr, nxt_ptr;
`endif
   spim_arbiter #(.NREQ(NREQ)) u_arb (
      .req     (bus.req),
`ifdef SPIM_ROUND_ROBIN_EN
      .ptr     (ptr),
      .nxt_ptr (nxt_ptr),
`endif
      .win     (win),
      .valid   (valid)
   );
   // winner's byte/slave mux and next-state decode; GAP uses its own length, every other phase lasts CLKDIV
   always_comb begin
      sel_data = '0;
      sel_slv = '0;
      for (int r = 0; r < NREQ; r++) begin
         sel_data = sel_data | (win[r] ? bus.req_data[8*r +: 8] : 8'h00);
         sel_slv = sel_slv | (win[r] ? bus.req_slv[SW*r +: SW] : '0);
      end
      last = divc == ((st == ST_GAP) ? DW'(GAP - 1) : DW'(CLKDIV - 1));
      take = st == ST_IDLE && valid;
      nxt = st;
      if (take) nxt = ST_SETUP;
      else if (st != ST_IDLE && last)
         nxt = (st == ST_SETUP || st == ST_LOW) ? ST_HIGH :
               (st == ST_HIGH) ? ((bitc == 3'd7) ? ST_TAIL : ST_LOW) :
               (st == ST_TAIL) ? ST_GAP : ST_IDLE;
   end
   // state, counters, shift registers and the one-cycle grant/done pulses; miso is taken on each sck rise
   always_ff @(posedge Clk_i) begin
      if (!Rst_ni) begin
         st <= ST_IDLE;
         divc <= '0;
         bitc <= '0;
         tx <= '0;
         rx <= '0;
         slv <= '0;
         own <= '0;
         bus.gnt <= '0;
         bus.done <= '0;
         bus.rx_data <= '0;
`ifdef SPIM_ROUND_ROBIN_EN
         ptr <= '0;
`endif
      end else begin
         st <= nxt;
         divc <= (nxt != st || st == ST_IDLE) ? '0 : divc + 1'b1;
         bus.gnt <= take ? win : '0;
         bus.done <= (st == ST_TAIL && last) ? own : '0;
         if (st == ST_TAIL && last) bus.rx_data <= rx;
         if (nxt == ST_HIGH && st != ST_HIGH) rx <= {rx[6:0], bus.miso};
         if (take) begin
            tx <= sel_data;
            slv <= sel_slv;
            own <= win;
            bitc <= '0;
`ifdef SPIM_ROUND_ROBIN_EN
            ptr <= nxt_ptr;
`endif
         end else if (st == ST_HIGH && last && bitc != 3'd7) begin
            tx <= {tx[6:0], 1'b0};
            bitc <= bitc + 3'd1;
         end
      end
   end
   assign on = st inside {ST_SETUP, ST_HIGH, ST_LOW, ST_TAIL};
   assign bus.busy = st != ST_IDLE;
   assign bus.sck = st == ST_HIGH;
   assign bus.mosi = tx[7];
   assign bus.ss = (on && int'(slv) < NSLV) ? NSLV'(1) << slv : '0;
endmodule

// File: tb/tb_spi_master_sched.sv
// tb_spi_master_sched: directed checks of spi_master_sched with CLKDIV=4, GAP=4
module tb_spi_master_sched;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   logic [7:0] slave_byte = 8'h00;
   logic [7:0] sreg = 8'h00;
   logic [7:0] mosi_log = 8'h00;
   logic [2:0] sck_p = 3'b000;

   spi_master_sched_if #(.NREQ(4), .NSLV(4)) bus ();
   spi_master_sched #(.NREQ(4), .NSLV(4), .CLKDIV(4), .GAP(4)) dut (.Clk_i(clk), .Rst_ni(rst_n), .bus(bus));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   assign bus.miso = sreg[7];

   // slave model: loads its byte while idle, logs mosi after each sck rise, shifts miso 3 clocks after the rise
   always @(posedge clk) begin
      sck_p <= {sck_p[1:0], bus.sck};
      if (bus.sck && !sck_p[0]) mosi_log <= {mosi_log[6:0], bus.mosi};
      if (!bus.busy) sreg <= slave_byte;
      else if (sck_p[1] && !sck_p[2]) sreg <= {sreg[6:0], 1'b0};
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_gnt(output logic [3:0] g, output int t);
      g = '0;
      for (int i = 0; i < 300 && g == 4'b0; i++) begin
         @(negedge clk);
         g = bus.gnt;
      end
      t = cyc;
   endtask

   task automatic wait_done(output logic [3:0] g, output int t);
      g = '0;
      for (int i = 0; i < 300 && g == 4'b0; i++) begin
         @(negedge clk);
         g = bus.done;
      end
      t = cyc;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 100 && bus.busy; i++) @(negedge clk);
      chk("idle_reached", bus.busy, 1'b0);
   endtask

   initial begin
      logic [3:0] g;
      int t0, t1, n;
      bus.req = '0;
      bus.req_data = '0;
      bus.req_slv = '0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", {bus.sck, bus.mosi, bus.ss, bus.gnt, bus.done, bus.rx_data, bus.busy}, 0);
      rst_n = 1'b1;
      @(negedge clk);
      // single transfer: client 0 sends A5 to slave 2, slave returns 3C
      slave_byte = 8'h3C;
      bus.req_data[7:0] = 8'hA5;
      bus.req_slv[1:0] = 2'd2;
      bus.req = 4'b0001;
      wait_gnt(g, t0);
      chk("single_gnt", g, 4'b0001);
      chk("single_busy", bus.busy, 1'b1);
      bus.req = '0;
      n = 0;
      g = '0;
      for (int i = 0; i < 300 && g == 4'b0; i++) begin
         n += (bus.ss == 4'b0100) ? 1 : 0;
         @(negedge clk);
         g = bus.done;
      end
      t1 = cyc;
      chk("single_done", g, 4'b0001);
      chk("single_latency", t1 - t0, 68);
      chk("single_ss_cycles", n, 68);
      chk("single_rx", bus.rx_data, 8'h3C);
      chk("single_mosi", mosi_log, 8'hA5);
      wait_idle();
      chk("single_rx_held", bus.rx_data, 8'h3C);
      // contention: all four clients request continuously from a fresh reset
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      bus.req_data = 32'h44332211;
      bus.req_slv = 8'b11100100;
      slave_byte = 8'h00;
      bus.req = 4'b1111;
      t0 = 0;
      for (int k = 0; k < 5; k++) begin
         wait_gnt(g, t1);
`ifdef SPIM_ROUND_ROBIN_EN
         chk($sformatf("rr_gnt%0d", k), g, 4'b0001 << (k % 4));
`else
         chk($sformatf("fixed_gnt%0d", k), g, 4'b0001);
`endif
         if (k > 0) chk($sformatf("gnt_spacing%0d", k), t1 - t0, 73);
         t0 = t1;
      end
      bus.req = '0;
      wait_done(g, t1);
      wait_idle();
      // back-to-back: client 1 holds its request, sends 01 then FF
      slave_byte = 8'h81;
      bus.req_data[15:8] = 8'h01;
      bus.req_slv[3:2] = 2'd1;
      bus.req = 4'b0010;
      wait_gnt(g, t0);
      chk("b2b_gnt1", g, 4'b0010);
      bus.req_data[15:8] = 8'hFF;
      wait_done(g, t0);
      chk("b2b_done1", g, 4'b0010);
      chk("b2b_rx1", bus.rx_data, 8'h81);
      chk("b2b_mosi1", mosi_log, 8'h01);
      slave_byte = 8'h7E;
      n = 0;
      g = '0;
      for (int i = 0; i < 300 && g == 4'b0; i++) begin
         n += (bus.busy && bus.ss == 4'b0000) ? 1 : 0;
         @(negedge clk);
         g = bus.gnt;
      end
      chk("b2b_gnt2", g, 4'b0010);
      chk("b2b_ss_gap", n, 4);
      bus.req = '0;
      wait_done(g, t1);
      chk("b2b_done2", g, 4'b0010);
      chk("b2b_period", t1 - t0, 73);
      chk("b2b_rx2", bus.rx_data, 8'h7E);
      chk("b2b_mosi2", mosi_log, 8'hFF);
      wait_idle();
      // reset mid-transfer after the third sck rise
      slave_byte = 8'h5A;
      bus.req_data[23:16] = 8'hC3;
      bus.req_slv[5:4] = 2'd1;
      bus.req = 4'b0100;
      wait_gnt(g, t0);
      chk("rst_gnt", g, 4'b0100);
      bus.req = '0;
      repeat (20) @(negedge clk);
      chk("rst_third_high", bus.sck, 1'b1);
      chk("rst_ss_before", bus.ss, 4'b0010);
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst_outputs", {bus.sck, bus.mosi, bus.ss, bus.gnt, bus.done, bus.rx_data, bus.busy}, 0);
      rst_n = 1'b1;
      n = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         n += (bus.done != 4'b0) ? 1 : 0;
      end
      chk("rst_no_done", n, 0);
      slave_byte = 8'h96;
      bus.req = 4'b0100;
      wait_gnt(g, t0);
      chk("rst_regnt", g, 4'b0100);
      bus.req = '0;
      wait_done(g, t1);
      chk("rst_redone", g, 4'b0100);
      chk("rst_relatency", t1 - t0, 68);
      chk("rst_rerx", bus.rx_data, 8'h96);
      chk("rst_remosi", mosi_log, 8'hC3);
      wait_idle();
      // late requester: client 3 rises during a client-2 transfer
      bus.req = 4'b0100;
      wait_gnt(g, t0);
      chk("late_gnt2", g, 4'b0100);
      bus.req = '0;
      repeat (10) @(negedge clk);
      bus.req = 4'b1000;
      wait_done(g, t1);
      chk("late_done2", g, 4'b0100);
      n = t1;
      wait_gnt(g, t1);
      chk("late_gnt3", g, 4'b1000);
      chk("late_gnt3_after_done", t1 - n, 5);
      chk("late_gnt3_spacing", t1 - t0, 73);
      bus.req = '0;
      wait_done(g, t1);
      chk("late_done3", g, 4'b1000);
      wait_idle();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
